// File: rtl/cma_pkg.sv
// Shared types and AXI encodings for cache_axi_master; field widths live in AXI_define.svh.
package cma_pkg;
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP} cma_state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam int         LINE_BEATS = 4;
endpackage

// File: rtl/AXI_define.svh
// AXI channel field widths shared by the cache AXI master and its bench.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_ID_BITS    4
`define AXI_ADDR_BITS  32
`define AXI_LEN_BITS   8
`define AXI_SIZE_BITS  3
`define AXI_BURST_BITS 2
`define AXI_DATA_BITS  32
`define AXI_STRB_BITS  4
`define AXI_RESP_BITS  2
`endif

// File: rtl/cache_axi_master.sv
// Single-outstanding AXI master for a cache: word writes, line-fill reads.
// Define CMA_BURST_EN for 4-beat line reads; otherwise reads are single aligned words.
`include "AXI_define.svh"

module cache_axi_master
  import cma_pkg::*;
#(
  parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [31:0]                 req_addr,
  input  logic [31:0]                 req_wdata,
  input  logic [3:0]                  req_wstrb,
  output logic [31:0]                 rsp_data,
  output logic                        rsp_valid,
  output logic                        rsp_last,
  output logic                        rsp_done,
  output logic                        rsp_err,
  output logic [`AXI_ID_BITS-1:0]     arid,
  output logic [`AXI_ADDR_BITS-1:0]   araddr,
  output logic [`AXI_LEN_BITS-1:0]    arlen,
  output logic [`AXI_SIZE_BITS-1:0]   arsize,
  output logic [`AXI_BURST_BITS-1:0]  arburst,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [`AXI_ID_BITS-1:0]     rid,
  input  logic [`AXI_DATA_BITS-1:0]   rdata,
  input  logic [`AXI_RESP_BITS-1:0]   rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  output logic [`AXI_ID_BITS-1:0]     awid,
  output logic [`AXI_ADDR_BITS-1:0]   awaddr,
  output logic [`AXI_LEN_BITS-1:0]    awlen,
  output logic [`AXI_SIZE_BITS-1:0]   awsize,
  output logic [`AXI_BURST_BITS-1:0]  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [`AXI_DATA_BITS-1:0]   wdata,
  output logic [`AXI_STRB_BITS-1:0]   wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [`AXI_ID_BITS-1:0]     bid,
  input  logic [`AXI_RESP_BITS-1:0]   bresp,
  input  logic                        bvalid,
  output logic                        bready,
  output cma_state_t                  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both high;
  // VALID and its payload stay stable until that edge, and READY never waits on VALID.

  cma_state_t  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        err_q;
  logic        beat_err;

`ifdef CMA_BURST_EN
  localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);
  localparam int         AR_LEN    = LINE_BEATS - 1;
  logic [1:0] beat_cnt;
  assign araddr = {addr_q[31:4], 4'b0000};
`else
  localparam int         AR_LEN    = 0;
  assign araddr = {addr_q[31:2], 2'b00};
`endif

  assign req_ready = (state == IDLE);
  assign state_dbg = state;
  assign arid      = MASTER_ID;
  assign arlen     = AR_LEN[`AXI_LEN_BITS-1:0];
  assign arsize    = SIZE_WORD;
  assign arburst   = BURST_INCR;
  assign awid      = MASTER_ID;
  assign awaddr    = addr_q;
  assign awlen     = '0;
  assign awsize    = SIZE_WORD;
  assign awburst   = BURST_INCR;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wlast     = 1'b1;

  // A beat is bad on a non-OKAY response, a foreign ID, or RLAST arriving at the wrong count.
  always_comb begin
    beat_err = (rresp != RESP_OKAY) || (rid != MASTER_ID);
`ifdef CMA_BURST_EN
    if (rlast) beat_err = beat_err || (beat_cnt != LAST_BEAT);
    else       beat_err = beat_err || (beat_cnt == LAST_BEAT);
`else
    if (!rlast) beat_err = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      err_q     <= 1'b0;
      arvalid   <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      rready    <= 1'b0;
      bready    <= 1'b0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_done  <= 1'b0;
      rsp_err   <= 1'b0;
`ifdef CMA_BURST_EN
      beat_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_done  <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          wstrb_q <= req_wstrb;
          if (req_write) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= WREQ;
          end else begin
            arvalid <= 1'b1;
            state   <= RADDR;
          end
        end
        RADDR: if (arready) begin
          arvalid  <= 1'b0;
          rready   <= 1'b1;
          err_q    <= 1'b0;
`ifdef CMA_BURST_EN
          beat_cnt <= '0;
`endif
          state    <= RDATA;
        end
        RDATA: if (rvalid) begin
          rsp_data  <= rdata;
          rsp_valid <= 1'b1;
          if (rlast) begin
            rsp_last <= 1'b1;
            rsp_done <= 1'b1;
            rsp_err  <= err_q || beat_err;
            rready   <= 1'b0;
            state    <= IDLE;
          end else begin
            err_q    <= err_q || beat_err;
`ifdef CMA_BURST_EN
            beat_cnt <= beat_cnt + 2'd1;
`endif
          end
        end
        WREQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          // Each channel is finished once it has handshaken, now or on an earlier edge.
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= WRESP;
          end
        end
        WRESP: if (bvalid) begin
          bready   <= 1'b0;
          rsp_done <= 1'b1;
          rsp_err  <= (bresp != RESP_OKAY) || (bid != MASTER_ID);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_axi_master.sv
// Directed bench for cache_axi_master; burst-read cases follow CMA_BURST_EN.
`include "AXI_define.svh"

module tb_cache_axi_master;
  import cma_pkg::*;

`ifdef CMA_BURST_EN
  localparam int          NB       = 4;
  localparam logic [31:0] EXP_LEN  = 32'd3;
  localparam logic [31:0] RD_ADDR0 = 32'h0000_1230;
  localparam logic [31:0] RD_ADDR1 = 32'h0000_2000;
  localparam int          NB_BAD   = 3;
`else
  localparam int          NB       = 1;
  localparam logic [31:0] EXP_LEN  = 32'd0;
  localparam logic [31:0] RD_ADDR0 = 32'h0000_1234;
  localparam logic [31:0] RD_ADDR1 = 32'h0000_2008;
  localparam int          NB_BAD   = 2;
`endif

  logic clk, rst_n;
  logic req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] rsp_data;
  logic rsp_valid, rsp_last, rsp_done, rsp_err;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  cma_state_t  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int ar_cnt   = 0;
  logic last_err = 1'b0;
  logic [32:0] exp_q[$];

  cache_axi_master #(.MASTER_ID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
    .rsp_done(rsp_done), .rsp_err(rsp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: read beats popped from exp_q, done pulses and AR handshakes counted
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e[31:0]);
          check("rsp_last", {31'b0, rsp_last}, {31'b0, e[32]});
          check("done_with_last", {31'b0, rsp_done}, {31'b0, e[32]});
        end
      end
      if (rsp_done) begin
        done_cnt++;
        last_err = rsp_err;
      end
      if (arvalid && arready) ar_cnt++;
    end
  end

  // Driver tasks
  task automatic start_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] id, input logic [1:0] resp,
                           input logic last, input int gap);
    rvalid = 1'b0;
    repeat (gap) tick();
    check("rready_in_rdata", {31'b0, rready}, 32'd1);
    rdata = d; rid = id; rresp = resp; rlast = last; rvalid = 1'b1;
    exp_q.push_back({last, d});
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic run_read(input string tag, input logic [31:0] a, input logic [31:0] exp_araddr,
                          input int nb, input logic [3:0] id, input logic [1:0] resp,
                          input int gap, input int ar_delay, input logic exp_err);
    int d0;
    start_req(1'b0, a, 32'h0, 4'h0);
    check({tag, "_arvalid"}, {31'b0, arvalid}, 32'd1);
    check({tag, "_araddr"}, araddr, exp_araddr);
    check({tag, "_arlen"}, {24'b0, arlen}, EXP_LEN);
    check({tag, "_arsize"}, {29'b0, arsize}, 32'd2);
    check({tag, "_arburst"}, {30'b0, arburst}, 32'd1);
    check({tag, "_arid"}, {28'b0, arid}, 32'd0);
    repeat (ar_delay) tick();
    check({tag, "_arvalid_held"}, {31'b0, arvalid}, 32'd1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check({tag, "_state_rdata"}, {29'b0, state_dbg}, {29'b0, RDATA});
    d0 = done_cnt;
    for (int i = 0; i < nb; i++)
      send_beat(32'h0000_00A0 + 32'(i), id, resp, (i == nb - 1), (i == 0) ? 0 : gap);
    tick();
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_rsp_err"}, {31'b0, last_err}, {31'b0, exp_err});
    check({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, {29'b0, state_dbg}, {29'b0, IDLE});
  endtask

  initial begin
    int d0, a0;
    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valids", {29'b0, arvalid, awvalid, wvalid}, 32'd0);
    check("rst_readies", {30'b0, rready, bready}, 32'd0);
    check("rst_rsp", {28'b0, rsp_valid, rsp_last, rsp_done, rsp_err}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);

    // Aligned line/word read with ARREADY after 2 cycles
    run_read("rd_basic", 32'h0000_1234, RD_ADDR0, NB, 4'd0, 2'b00, 0, 2, 1'b0);

    // Write: WREADY one cycle before AWREADY
    d0 = done_cnt;
    start_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011);
    check("wr_awvalid", {31'b0, awvalid}, 32'd1);
    check("wr_wvalid", {31'b0, wvalid}, 32'd1);
    check("wr_awaddr", awaddr, 32'h0000_0010);
    check("wr_aw_fields", {16'b0, awlen, 1'b0, awsize, 2'b0, awburst}, 32'h0000_0021);
    check("wr_wdata", wdata, 32'hDEAD_BEEF);
    check("wr_wstrb_wlast", {27'b0, wlast, wstrb}, 32'h13);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    check("wr_w_first", {30'b0, awvalid, wvalid}, 32'b10);
    check("wr_no_bready_yet", {31'b0, bready}, 32'd0);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    check("wr_aw_done", {30'b0, awvalid, wvalid}, 32'd0);
    check("wr_bready", {31'b0, bready}, 32'd1);
    bvalid = 1'b1; bresp = 2'b00; bid = 4'd0;
    tick();
    bvalid = 1'b0;
    check("wr_rsp_done", {31'b0, rsp_done}, 32'd1);
    tick(); tick();
    check("wr_one_done", 32'(done_cnt - d0), 32'd1);
    check("wr_err", {31'b0, last_err}, 32'd0);

    // Write with simultaneous AW/W handshake and SLVERR
    start_req(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b1111);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    check("wr2_state_wresp", {29'b0, state_dbg}, {29'b0, WRESP});
    bvalid = 1'b1; bresp = 2'b10;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    check("wr2_done_err", {30'b0, rsp_done, rsp_err}, 32'b11);
    tick();

    // Read with wrong beat count and gaps between beats
    run_read("rd_count", 32'h0000_2008, RD_ADDR1, NB_BAD, 4'd0, 2'b00, 3, 0, 1'b1);
    // Read with a foreign RID and with a SLVERR response
    run_read("rd_rid", 32'h0000_2008, RD_ADDR1, NB, 4'd5, 2'b00, 0, 1, 1'b1);
    run_read("rd_resp", 32'h0000_2008, RD_ADDR1, NB, 4'd0, 2'b10, 1, 0, 1'b1);

    // Reset in RDATA after two beats
    start_req(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    send_beat(32'h0000_00B0, 4'd0, 2'b00, 1'b0, 0);
    send_beat(32'h0000_00B1, 4'd0, 2'b00, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valids", {29'b0, arvalid, awvalid, wvalid}, 32'd0);
    check("mid_rst_readies", {30'b0, rready, bready}, 32'd0);
    check("mid_rst_rsp", {28'b0, rsp_valid, rsp_last, rsp_done, rsp_err}, 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'd0);
    check("mid_rst_idle", {29'b0, state_dbg}, {29'b0, IDLE});
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (5) tick();
    check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_read("rd_after_rst", 32'h0000_1234, RD_ADDR0, NB, 4'd0, 2'b00, 0, 0, 1'b0);

    // req_valid held high across a whole read
    a0 = ar_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040;
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < NB; i++)
      send_beat(32'h0000_00C0 + 32'(i), 4'd0, 2'b00, (i == NB - 1), 1);
    check("held_done", {31'b0, rsp_done}, 32'd1);
    check("held_one_ar", 32'(ar_cnt - a0), 32'd1);
    tick();
    check("held_second_accepted", {29'b0, state_dbg}, {29'b0, RADDR});
    req_valid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < NB; i++)
      send_beat(32'h0000_00D0 + 32'(i), 4'd0, 2'b00, (i == NB - 1), 0);
    tick();
    check("held_two_ar", 32'(ar_cnt - a0), 32'd2);
    check("held_beats_left", 32'(exp_q.size()), 32'd0);
    check("held_idle", {29'b0, state_dbg}, {29'b0, IDLE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
